// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_pkg : op codes, FSM states and op-class helpers             |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10,
    OP_MUL   = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mul(input op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                      OP_MSUB, OP_MSUBU, OP_MUL};
  endfunction

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_multicycle(input op_e op);
    return is_mul(op) || is_div(op);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_div_iter : radix-2 restoring divider, one bit per cycle     |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_dividend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;

  assign w_mag_a = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_divisor};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_cnt      <= '0;
      r_quo      <= w_mag_a;
      r_rem      <= '0;
      r_divisor  <= w_mag_b;
      r_dividend <= i_a;
      r_neg_q    <= i_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r    <= i_is_signed && i_a[WIDTH-1];
      r_div0     <= (i_b == '0);
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      // A set top bit of the difference means the trial went negative: restore.
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_last) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == c_last);
  assign o_q    = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_quo : r_quo);
  assign o_r    = r_div0 ? r_dividend : (r_neg_r ? -r_rem : r_rem);

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_unit : multi-lane multiply/divide unit owning HI/LO         |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LANES   = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*LANES-1:0]     op_i,
  input  logic [WIDTH*LANES-1:0] a_i,
  input  logic [WIDTH*LANES-1:0] b_i,
  input  logic [LANES-1:0]       flush_i,
  output logic                   stall_o,
  output logic [LANES-1:0]       done_o,
  output logic [WIDTH*LANES-1:0] res_o,
  output logic [WIDTH-1:0]       hi_o,
  output logic [WIDTH-1:0]       lo_o
);

  localparam int OW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int PW  = 2 * WIDTH;
  localparam logic [MCW-1:0] c_mul_last = MCW'(MUL_LAT - 1);

  state_e           r_state, w_next;
  logic [OW-1:0]    r_owner;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [LANES-1:0] r_done_mask;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_res [LANES];
  logic [PW-1:0]    r_mul_pipe [MUL_LAT];
  logic [MCW-1:0]   r_mul_cnt;

  op_e              w_op [LANES];
  logic [WIDTH-1:0] w_a [LANES];
  logic [WIDTH-1:0] w_b [LANES];
  logic [LANES-1:0] w_pending, w_avail;
  logic [OW-1:0]    w_pick;
  op_e              w_pick_op;
  logic             w_start, w_owner_flush, w_commit;
  logic [PW-1:0]    w_ma, w_mb, w_prod, w_p, w_acc;
  logic [WIDTH-1:0] w_hi, w_lo;
  logic             w_div_busy, w_div_done;
  logic [WIDTH-1:0] w_div_q, w_div_r;

  assign w_owner_flush = flush_i[r_owner];
  assign w_commit      = (r_state == ST_DONE) && !w_owner_flush;

  // The owner in DONE is committing this cycle, so it is not a start candidate.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_op[g]      = op_e'(op_i[4*g +: 4]);
    assign w_a[g]       = a_i[WIDTH*g +: WIDTH];
    assign w_b[g]       = b_i[WIDTH*g +: WIDTH];
    assign w_pending[g] = is_multicycle(w_op[g]) && !r_done_mask[g] && !flush_i[g];
    assign w_avail[g]   = w_pending[g] && !((r_state == ST_DONE) && (r_owner == OW'(g)));
    assign done_o[g]    = w_commit && (r_owner == OW'(g));
    assign res_o[WIDTH*g +: WIDTH] = (done_o[g] && (r_op == OP_MUL)) ? w_p[WIDTH-1:0] : r_res[g];
  end

  always_comb begin
    w_pick = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_avail[l]) w_pick = OW'(l);
    end
  end

  assign w_pick_op = w_op[w_pick];
  assign stall_o   = (|w_pending) && !((r_state == ST_DONE) && !(|w_avail));

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_next = ST_IDLE;
        if ((|w_avail) && !((r_state == ST_DONE) && w_owner_flush)) begin
          w_start = 1'b1;
          w_next  = is_div(w_pick_op) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (w_owner_flush)                w_next = ST_IDLE;
        else if (r_mul_cnt == c_mul_last) w_next = ST_DONE;
      end
      ST_DIV: begin
        if (w_owner_flush)    w_next = ST_IDLE;
        else if (w_div_done)  w_next = ST_DONE;
        else if (!w_div_busy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_ma   = is_signed_op(r_op) ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_mb   = is_signed_op(r_op) ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_p    = r_mul_pipe[MUL_LAT-1];
  assign w_acc  = {r_hi, r_lo};

  muldiv_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start && is_div(w_pick_op)),
    .i_is_signed(w_pick_op == OP_DIV),
    .i_flush    ((r_state == ST_DIV) && w_owner_flush),
    .i_a        (w_a[w_pick]),
    .i_b        (w_b[w_pick]),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_q        (w_div_q),
    .o_r        (w_div_r)
  );

  // Commit first, then MTx in lane order so a later lane always wins.
  always_comb begin
    w_hi = r_hi;
    w_lo = r_lo;
    if (w_commit) begin
      case (r_op)
        OP_MULT, OP_MULTU: {w_hi, w_lo} = w_p;
        OP_MADD, OP_MADDU: {w_hi, w_lo} = w_acc + w_p;
        OP_MSUB, OP_MSUBU: {w_hi, w_lo} = w_acc - w_p;
        OP_DIV, OP_DIVU: begin
          w_hi = w_div_r;
          w_lo = w_div_q;
        end
        default: ;
      endcase
    end
    if (!stall_o) begin
      for (int l = 0; l < LANES; l++) begin
        if (!flush_i[l]) begin
          if (w_op[l] == OP_MTHI)      w_hi = w_a[l];
          else if (w_op[l] == OP_MTLO) w_lo = w_a[l];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_op        <= OP_NONE;
      r_a         <= '0;
      r_b         <= '0;
      r_done_mask <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mul_cnt   <= '0;
      for (int l = 0; l < LANES; l++) r_res[l] <= '0;
      for (int s = 0; s < MUL_LAT; s++) r_mul_pipe[s] <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_owner <= w_pick;
        r_op    <= w_pick_op;
        r_a     <= w_a[w_pick];
        r_b     <= w_b[w_pick];
      end
      r_mul_cnt <= (r_state == ST_MUL) ? r_mul_cnt + 1'b1 : '0;
      if (r_state == ST_MUL) begin
        r_mul_pipe[0] <= w_prod;
        for (int s = 1; s < MUL_LAT; s++) r_mul_pipe[s] <= r_mul_pipe[s-1];
      end
      if (!stall_o)      r_done_mask <= '0;
      else if (w_commit) r_done_mask[r_owner] <= 1'b1;
      r_hi <= w_hi;
      r_lo <= w_lo;
      for (int l = 0; l < LANES; l++) begin
        if (done_o[l] && (r_op == OP_MUL)) r_res[l] <= w_p[WIDTH-1:0];
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muldiv_unit : scoreboard bench for muldiv_unit (32-bit, 2 lanes)|
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  op_i;
  logic [63:0] a_i, b_i;
  logic [1:0]  flush_i;
  logic        stall_o;
  logic [1:0]  done_o;
  logic [63:0] res_o;
  logic [31:0] hi_o, lo_o;

  typedef struct {
    int          lane;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chk_res;
    logic [31:0] res;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          c0 = 0;
  bit          hl_pend = 0;
  logic [31:0] hl_hi, hl_lo;

  muldiv_unit #(.WIDTH(32), .LANES(2), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .res_o(res_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int lane, input int off, input logic [31:0] hi, input logic [31:0] lo,
                      input bit cr, input logic [31:0] res);
    exp_t e;
    e.lane = lane; e.cyc = c0 + off; e.hi = hi; e.lo = lo; e.chk_res = cr; e.res = res;
    exp_q.push_back(e);
  endtask

  task automatic start_bundle(input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
    @(posedge clk); #1;
    c0   = cyc;
    op_i = {o1, o0};
    a_i  = {a1, a0};
    b_i  = {b1, b0};
  endtask

  task automatic clear_bundle();
    @(posedge clk); #1;
    op_i = '0; a_i = '0; b_i = '0; flush_i = '0;
  endtask

  // Counts stall cycles from cycle 0 until the first stall-low cycle.
  task automatic wait_stall(input int exp_n, input string name);
    int n = 0;
    bit ended = 0;
    for (int i = 0; i < 200 && !ended; i++) begin
      @(negedge clk);
      if (stall_o) n++;
      else ended = 1;
    end
    if (!ended) begin
      failures++;
      $display("FAIL %s_timeout actual=stall_stuck required=stall_low", name);
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  // Monitor: compares every done_o pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (hl_pend) begin
      hl_pend = 0;
      chk("sb_hi", 64'(hi_o), 64'(hl_hi));
      chk("sb_lo", 64'(lo_o), 64'(hl_lo));
    end
    if (rst && done_o != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 64'(done_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_done_lane", 64'(done_o), 64'(2'b01 << e.lane));
        chk("sb_done_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk_res) chk("sb_res", 64'(res_o[e.lane*32 +: 32]), 64'(e.res));
        hl_pend = 1;
        hl_hi = e.hi;
        hl_lo = e.lo;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(hi_o), 64'(0));
    chk("reset_lo", 64'(lo_o), 64'(0));
    chk("reset_done", 64'(done_o), 64'(0));
    chk("reset_stall", 64'(stall_o), 64'(0));
    chk("reset_res", res_o, 64'(0));

    // Signed MULT: -2 * 3
    start_bundle(OP_MULT, 32'hFFFFFFFE, 32'd3, OP_NONE, 0, 0);
    push(0, 3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
    wait_stall(3, "mult_stall");

    // Signed DIV on lane 1: -7 / 2
    start_bundle(OP_NONE, 0, 0, OP_DIV, 32'hFFFFFFF9, 32'd2);
    push(1, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    wait_stall(33, "div_stall");

    // Unsigned divide by zero
    start_bundle(OP_DIVU, 32'h00001234, 32'd0, OP_NONE, 0, 0);
    push(0, 33, 32'h00001234, 32'hFFFFFFFF, 0, 0);
    wait_stall(33, "divu0_stall");

    // Later-lane MTLO overrides earlier-lane MTLO; then clear HI
    start_bundle(OP_MTLO, 32'h11111111, 0, OP_MTLO, 32'd0, 0);
    wait_stall(0, "mtlo_stall");
    start_bundle(OP_MTHI, 32'd0, 0, OP_NONE, 0, 0);
    wait_stall(0, "mthi_stall");
    clear_bundle();
    @(negedge clk);
    chk("mtx_hi", 64'(hi_o), 64'(0));
    chk("mtx_lo", 64'(lo_o), 64'(0));

    // Back-to-back: MULTU then MADDU
    start_bundle(OP_MULTU, 32'h00010000, 32'h00010000, OP_MADDU, 32'd2, 32'd3);
    push(0, 3, 32'd1, 32'd0, 0, 0);
    push(1, 6, 32'd1, 32'd6, 0, 0);
    wait_stall(6, "b2b_stall");

    // Lane0 MUL (-3*7, HI/LO untouched) then lane1 signed MSUB of -1
    start_bundle(OP_MUL, 32'hFFFFFFFD, 32'd7, OP_MSUB, 32'hFFFFFFFF, 32'd1);
    push(0, 3, 32'd1, 32'd6, 1, 32'hFFFFFFEB);
    push(1, 6, 32'd1, 32'd7, 0, 0);
    wait_stall(6, "mul_msub_stall");

    // MIN / -1 with later-lane MTHI overriding the commit
    start_bundle(OP_DIV, 32'h80000000, 32'hFFFFFFFF, OP_MTHI, 32'h0000DEAD, 0);
    push(0, 33, 32'h0000DEAD, 32'h80000000, 0, 0);
    wait_stall(33, "minneg1_stall");

    // Signed divide by zero then DIVU on lane 1
    start_bundle(OP_DIV, 32'hFFFFFFFB, 32'd0, OP_DIVU, 32'hFFFFFFFF, 32'h10);
    push(0, 33, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 0);
    push(1, 66, 32'h0000000F, 32'h0FFFFFFF, 0, 0);
    wait_stall(66, "div_pair_stall");

    // Flush of the owning lane mid-divide
    start_bundle(OP_MTHI, 32'h55, 0, OP_MTLO, 32'h55, 0);
    wait_stall(0, "mt55_stall");
    start_bundle(OP_DIV, 32'd100, 32'd7, OP_NONE, 0, 0);
    repeat (10) @(posedge clk);
    #1 flush_i = 2'b01;
    @(negedge clk);
    chk("flush_stall_c10", 64'(stall_o), 64'(0));
    clear_bundle();
    @(negedge clk);
    chk("flush_stall_c11", 64'(stall_o), 64'(0));
    chk("flush_hi", 64'(hi_o), 64'(32'h55));
    chk("flush_lo", 64'(lo_o), 64'(32'h55));
    start_bundle(OP_MULT, 32'd5, 32'd6, OP_NONE, 0, 0);
    push(0, 3, 32'd0, 32'd30, 0, 0);
    wait_stall(3, "post_flush_stall");

    // Younger lane flushed: older lane's op finishes alone
    start_bundle(OP_MULTU, 32'd3, 32'd4, OP_DIV, 32'd9, 32'd2);
    flush_i = 2'b10;
    push(0, 3, 32'd0, 32'd12, 0, 0);
    wait_stall(3, "young_flush_stall");
    clear_bundle();
    @(negedge clk);
    chk("res_hold", 64'(res_o[63:32]), 64'(0));
    chk("res0_hold", 64'(res_o[31:0]), 64'(32'hFFFFFFEB));

    // Asynchronous reset in cycle 5 of a divide
    start_bundle(OP_DIV, 32'd100, 32'd7, OP_NONE, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    op_i = '0;
    #1;
    chk("arst_hi", 64'(hi_o), 64'(0));
    chk("arst_lo", 64'(lo_o), 64'(0));
    chk("arst_res", res_o, 64'(0));
    chk("arst_done", 64'(done_o), 64'(0));
    chk("arst_stall", 64'(stall_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    start_bundle(OP_NONE, 0, 0, OP_MTLO, 32'hA5A5A5A5, 0);
    wait_stall(0, "mtlo_alone_stall");
    clear_bundle();
    @(negedge clk);
    chk("mtlo_alone_lo", 64'(lo_o), 64'(32'hA5A5A5A5));
    chk("mtlo_alone_hi", 64'(hi_o), 64'(0));

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
